control_unit: RTL

CONTROL_UNIT -- requirements
Module: control_unit

---
 rtl/control_unit.sv | 225 ++++++++++++++++++++++
 1 files changed

// File: rtl/control_unit.sv
// control_unit: Moore-style instruction sequencer for a basic accumulator
// machine. Steps IDLE -> FETCH -> DECODE -> [INDIR] -> EXEC, with sticky
// HALT/ERR states. Every output is a flop; strobes come from a latched copy
// of the instruction word, never from the live i_ir bus.
module control_unit #(
  parameter int FETCH_CYCLES = 4,
  parameter int TIMEOUT      = 15
) (
  input  logic        clk,
  input  logic        i_clr_reg,
  input  logic        i_start,
  input  logic [15:0] i_ir,
  input  logic        i_ex_done,
  input  logic        i_w_mem_ref,
  output logic        o_fetch,
  output logic        o_execute,
  output logic        o_is_ind,
  output logic        o_is_dir,
  output logic        o_clr_ac,
  output logic        o_clr_e,
  output logic        o_comp_ac,
  output logic        o_load_ac,
  output logic        o_cir_r,
  output logic        o_cir_l,
  output logic        o_inc_ac,
  output logic        o_add,
  output logic        o_load,
  output logic        o_store,
  output logic        o_branch,
  output logic        o_isz,
  output logic        o_halt,
  output logic        o_err,
  output logic [2:0]  o_state
);

  localparam int FW = $clog2(FETCH_CYCLES + 1);
  localparam int TW = $clog2(TIMEOUT + 1);

  typedef enum logic [2:0] {
    S_IDLE   = 3'd0,
    S_FETCH  = 3'd1,
    S_DECODE = 3'd2,
    S_INDIR  = 3'd3,
    S_EXEC   = 3'd4,
    S_HALT   = 3'd5,
    S_ERR    = 3'd6
  } state_t;

  typedef struct packed {
    logic fetch;
    logic execute;
    logic is_ind;
    logic is_dir;
    logic clr_ac;
    logic clr_e;
    logic comp_ac;
    logic load_ac;
    logic cir_r;
    logic cir_l;
    logic inc_ac;
    logic add;
    logic load;
    logic store;
    logic branch;
    logic isz;
    logic halt;
    logic err;
  } ctl_t;

  state_t          state_q, state_d;
  logic [FW-1:0]   fcnt_q, fcnt_d;
  logic [TW-1:0]   wcnt_q, wcnt_d;
  logic [15:0]     ir_q, ir_d;
  ctl_t            ctl_q, ctl_d;

  logic            ind_bit;
  logic [2:0]      opcode;
  logic [3:0]      rop;
  logic            is_mem, is_reg, is_hlt, is_ill;

  assign ind_bit = ir_q[15];
  assign opcode  = ir_q[14:12];
  assign rop     = ir_q[11:8];

  // Classify the latched instruction word.
  always_comb begin
    is_mem = 1'b0;
    is_reg = 1'b0;
    is_hlt = 1'b0;
    is_ill = 1'b0;
    case (opcode)
      3'b001, 3'b010, 3'b011, 3'b100, 3'b110: is_mem = 1'b1;
      3'b111: begin
        if (ind_bit) begin
          is_ill = 1'b1;
        end else begin
          case (rop)
            4'b0001, 4'b0010, 4'b0011, 4'b0100,
            4'b0101, 4'b0110, 4'b0111: is_reg = 1'b1;
            4'b1111:                   is_hlt = 1'b1;
            default:                   is_ill = 1'b1;
          endcase
        end
      end
      default: is_ill = 1'b1;
    endcase
  end

  // Next-state logic: counters default to zero so they clear on every state change.
  always_comb begin
    state_d = state_q;
    fcnt_d  = '0;
    wcnt_d  = '0;
    ir_d    = ir_q;
    case (state_q)
      S_IDLE: begin
        if (i_start) state_d = S_FETCH;
      end
      S_FETCH: begin
        if (fcnt_q == FW'(FETCH_CYCLES - 1)) begin
          state_d = S_DECODE;
          ir_d    = i_ir;
        end else begin
          fcnt_d = fcnt_q + 1'b1;
        end
      end
      S_DECODE: begin
        if (is_hlt)                state_d = S_HALT;
        else if (is_ill)           state_d = S_ERR;
        else if (is_mem && ind_bit) state_d = S_INDIR;
        else                       state_d = S_EXEC;
      end
      S_INDIR: begin
        // The resolve flag takes priority over an expiring wait counter.
        if (i_w_mem_ref)                         state_d = S_EXEC;
        else if (wcnt_q == TW'(TIMEOUT - 1))     state_d = S_ERR;
        else                                     wcnt_d = wcnt_q + 1'b1;
      end
      S_EXEC: begin
        // i_start is only consulted here, so dropping it never aborts an instruction.
        if (i_ex_done)                           state_d = i_start ? S_FETCH : S_IDLE;
        else if (wcnt_q == TW'(TIMEOUT - 1))     state_d = S_ERR;
        else                                     wcnt_d = wcnt_q + 1'b1;
      end
      S_HALT:  state_d = S_HALT;
      S_ERR:   state_d = S_ERR;
      default: state_d = S_ERR;
    endcase
  end

  // Output decode from the upcoming state so outputs can be registered alongside it.
  always_comb begin
    ctl_d = '0;
    case (state_d)
      S_FETCH: ctl_d.fetch  = 1'b1;
      S_INDIR: ctl_d.is_ind = 1'b1;
      S_EXEC: begin
        ctl_d.execute = 1'b1;
        ctl_d.is_dir  = is_mem;
        if (is_mem) begin
          case (opcode)
            3'b001:  ctl_d.add    = 1'b1;
            3'b010:  ctl_d.load   = 1'b1;
            3'b011:  ctl_d.store  = 1'b1;
            3'b100:  ctl_d.branch = 1'b1;
            3'b110:  ctl_d.isz    = 1'b1;
            default: ;
          endcase
        end else if (is_reg) begin
          case (rop)
            4'b0001: ctl_d.clr_ac  = 1'b1;
            4'b0010: ctl_d.clr_e   = 1'b1;
            4'b0011: ctl_d.comp_ac = 1'b1;
            4'b0100: ctl_d.load_ac = 1'b1;
            4'b0101: ctl_d.cir_r   = 1'b1;
            4'b0110: ctl_d.cir_l   = 1'b1;
            4'b0111: ctl_d.inc_ac  = 1'b1;
            default: ;
          endcase
        end
      end
      S_HALT:  ctl_d.halt = 1'b1;
      S_ERR:   ctl_d.err  = 1'b1;
      default: ;
    endcase
  end

  // State, counters, decode register and output flops; i_clr_reg clears all asynchronously.
  always_ff @(posedge clk or posedge i_clr_reg) begin
    if (i_clr_reg) begin
      state_q <= S_IDLE;
      fcnt_q  <= '0;
      wcnt_q  <= '0;
      ir_q    <= '0;
      ctl_q   <= '0;
    end else begin
      state_q <= state_d;
      fcnt_q  <= fcnt_d;
      wcnt_q  <= wcnt_d;
      ir_q    <= ir_d;
      ctl_q   <= ctl_d;
    end
  end

  assign o_fetch   = ctl_q.fetch;
  assign o_execute = ctl_q.execute;
  assign o_is_ind  = ctl_q.is_ind;
  assign o_is_dir  = ctl_q.is_dir;
  assign o_clr_ac  = ctl_q.clr_ac;
  assign o_clr_e   = ctl_q.clr_e;
  assign o_comp_ac = ctl_q.comp_ac;
  assign o_load_ac = ctl_q.load_ac;
  assign o_cir_r   = ctl_q.cir_r;
  assign o_cir_l   = ctl_q.cir_l;
  assign o_inc_ac  = ctl_q.inc_ac;
  assign o_add     = ctl_q.add;
  assign o_load    = ctl_q.load;
  assign o_store   = ctl_q.store;
  assign o_branch  = ctl_q.branch;
  assign o_isz     = ctl_q.isz;
  assign o_halt    = ctl_q.halt;
  assign o_err     = ctl_q.err;
  assign o_state   = state_q;

endmodule
